// File: rtl/ula_multiciclo.sv
// Multi-cycle ALU: single-cycle logic/arith/slt ops plus iterative unsigned
// shift-add multiply and restoring divide, with start/busy/done handshake.
module ula_multiciclo #(
   parameter int unsigned LARGURA = 16
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               inicio,
   input  logic [LARGURA-1:0] entrada1,
   input  logic [LARGURA-1:0] entrada2,
   input  logic [2:0]         sinal_ula,
   output logic [LARGURA-1:0] saida_ula,
   output logic [LARGURA-1:0] saida_hi,
   output logic               zero,
   output logic               overflow,
   output logic               div_zero,
   output logic               ocupado,
   output logic               pronto
);

   localparam int unsigned CW = $clog2(LARGURA + 1);

   typedef enum logic [1:0] {OCIOSO, MULT, DIV} t_estado;

   t_estado            r_estado;
   logic [CW-1:0]      r_cnt;
   logic [LARGURA-1:0] r_a;   // multiplicand or divisor
   logic [LARGURA-1:0] r_hi;  // partial-product high half or partial remainder
   logic [LARGURA-1:0] r_lo;  // multiplier shifting out / dividend shifting into quotient

   logic [LARGURA-1:0] w_soma, w_dif, w_res;
   logic               w_ovf;
   logic [LARGURA:0]   w_mul_soma;
   logic [LARGURA-1:0] w_mul_hi, w_mul_lo;
   logic [LARGURA:0]   w_div_parc, w_div_sub;
   logic               w_div_ok;
   logic [LARGURA-1:0] w_div_rem, w_div_q;
   logic               w_ultimo;

   always_comb begin
      w_soma = entrada1 + entrada2;
      w_dif  = entrada1 - entrada2;
      w_res  = '0;
      w_ovf  = 1'b0;
      unique case (sinal_ula)
         3'b000: w_res = entrada1 & entrada2;
         3'b001: w_res = entrada1 | entrada2;
         3'b010: begin
            w_res = w_soma;
            w_ovf = (entrada1[LARGURA-1] == entrada2[LARGURA-1]) &&
                    (w_soma[LARGURA-1] != entrada1[LARGURA-1]);
         end
         3'b011: begin
            w_res = w_dif;
            w_ovf = (entrada1[LARGURA-1] != entrada2[LARGURA-1]) &&
                    (w_dif[LARGURA-1] != entrada1[LARGURA-1]);
         end
         3'b100: w_res = (entrada1 < entrada2) ? '1 : '0;
         3'b111: w_res = ($signed(entrada1) < $signed(entrada2)) ? '1 : '0;
         default: w_res = '0;
      endcase

      // Shift-add step: add multiplicand if multiplier LSB set, then shift {hi,lo} right.
      w_mul_soma = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);
      w_mul_hi   = w_mul_soma[LARGURA:1];
      w_mul_lo   = {w_mul_soma[0], r_lo[LARGURA-1:1]};

      w_div_parc = {r_hi, r_lo[LARGURA-1]};
      w_div_sub  = w_div_parc - {1'b0, r_a};
      w_div_ok   = (w_div_parc >= {1'b0, r_a});
      w_div_rem  = w_div_ok ? w_div_sub[LARGURA-1:0] : w_div_parc[LARGURA-1:0];
      w_div_q    = {r_lo[LARGURA-2:0], w_div_ok};

      w_ultimo   = (r_cnt == CW'(LARGURA - 1));
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_estado  <= OCIOSO;
         r_cnt     <= '0;
         r_a       <= '0;
         r_hi      <= '0;
         r_lo      <= '0;
         saida_ula <= '0;
         saida_hi  <= '0;
         zero      <= 1'b1;
         overflow  <= 1'b0;
         div_zero  <= 1'b0;
         ocupado   <= 1'b0;
         pronto    <= 1'b0;
      end else begin
         pronto <= 1'b0;
         unique case (r_estado)
            OCIOSO: begin
               if (inicio) begin
                  if (sinal_ula == 3'b101) begin
                     r_a      <= entrada1;
                     r_lo     <= entrada2;
                     r_hi     <= '0;
                     r_cnt    <= '0;
                     ocupado  <= 1'b1;
                     r_estado <= MULT;
                  end else if (sinal_ula == 3'b110) begin
                     if (entrada2 == '0) begin
                        saida_ula <= '1;
                        saida_hi  <= entrada1;
                        zero      <= 1'b0;
                        overflow  <= 1'b0;
                        div_zero  <= 1'b1;
                        pronto    <= 1'b1;
                     end else begin
                        r_a      <= entrada2;
                        r_lo     <= entrada1;
                        r_hi     <= '0;
                        r_cnt    <= '0;
                        ocupado  <= 1'b1;
                        r_estado <= DIV;
                     end
                  end else begin
                     saida_ula <= w_res;
                     saida_hi  <= '0;
                     zero      <= (w_res == '0);
                     overflow  <= w_ovf;
                     div_zero  <= 1'b0;
                     pronto    <= 1'b1;
                  end
               end
            end
            MULT: begin
               r_hi  <= w_mul_hi;
               r_lo  <= w_mul_lo;
               r_cnt <= r_cnt + CW'(1);
               if (w_ultimo) begin
                  saida_ula <= w_mul_lo;
                  saida_hi  <= w_mul_hi;
                  zero      <= (w_mul_lo == '0);
                  overflow  <= (w_mul_hi != '0);
                  div_zero  <= 1'b0;
                  pronto    <= 1'b1;
                  ocupado   <= 1'b0;
                  r_estado  <= OCIOSO;
               end
            end
            DIV: begin
               r_hi  <= w_div_rem;
               r_lo  <= w_div_q;
               r_cnt <= r_cnt + CW'(1);
               if (w_ultimo) begin
                  saida_ula <= w_div_q;
                  saida_hi  <= w_div_rem;
                  zero      <= (w_div_q == '0);
                  overflow  <= 1'b0;
                  div_zero  <= 1'b0;
                  pronto    <= 1'b1;
                  ocupado   <= 1'b0;
                  r_estado  <= OCIOSO;
               end
            end
            default: r_estado <= OCIOSO;
         endcase
      end
   end

endmodule

// File: doc/ula_multiciclo.md
# ula_multiciclo

Parametrised multi-cycle ALU for the MIPS datapath, replacing the single-cycle 16-bit ALU. It retains the and/or/add/sub/slt opcodes with one-cycle latency. It adds signed slt, iterative unsigned multiply and divide, a HI result register, overflow and divide-by-zero flags, and a start/busy/done handshake so the control unit can stall on long operations.

## Interface
- LARGURA, 16: data width in bits; must be ≥ 2.
- clock  in  1  single clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- inicio  in  1  start request; sampled only when ocupado=0.
- entrada1  in  LARGURA  operand A.
- entrada2  in  LARGURA  operand B.
- sinal_ula  in  3  opcode, sampled with inicio.
- saida_ula  out  LARGURA  main result (low product / quotient), registered.
- saida_hi  out  LARGURA  high product / remainder; 0 for single-cycle ops.
- zero  out  1  1 when the latched saida_ula == 0.
- overflow  out  1  arithmetic overflow flag for the last operation.
- div_zero  out  1  last operation was a divide with entrada2 == 0.
- ocupado  out  1  multi-cycle operation in progress.
- pronto  out  1  one-cycle pulse: results valid and updated.

## Operation
- Opcodes:
  - 000 and.
  - 001 or.
  - 010 add.
  - 011 sub.
  - 100 slt unsigned: all-ones if A<B, else 0.
  - 101 mult unsigned: 2·LARGURA-bit product, hi→saida_hi, lo→saida_ula.
  - 110 div unsigned: quotient→saida_ula, remainder→saida_hi.
  - 111 slt signed: all-ones if $signed(A) < $signed(B), else 0.
- States:
  - OCIOSO: accepts inicio. Ops 000–100 and 111 complete here.
  - MULT: shift-add, one partial product per cycle, LSB of multiplier first.
  - DIV: restoring division, one quotient bit per cycle, MSB first.
- Transitions:
  - OCIOSO→MULT on inicio & op=101.
  - OCIOSO→DIV on inicio & op=110 & B≠0.
  - MULT/DIV→OCIOSO when iteration counter reaches LARGURA.
- Operand capture: operands and opcode are latched at the start edge. Input changes during ocupado have no effect.
- Arithmetic is modulo 2^LARGURA.
- overflow rules:
  - add: set when signs of A and B are equal and the sign of the sum differs.
  - sub: set when signs of A and B differ and the sign of the result differs from A.
  - mult: set when saida_hi ≠ 0.
  - All other ops: 0.
- Divide by zero does not enter DIV. It completes in OCIOSO with saida_ula = all-ones, saida_hi = A, div_zero=1, overflow=0.
- div_zero is 0 for every other operation.
- inicio while ocupado=1 is ignored entirely: not queued, no flag.
- Outputs hold their last values between operations. They update only on the edge that raises pronto.
- Reset value of every output: saida_ula=0, saida_hi=0, zero=1, overflow=0, div_zero=0, ocupado=0, pronto=0. State resets to OCIOSO and the counter to 0.

## Timing
- Start edge N is the rising edge where inicio=1 and ocupado=0.
- Single-cycle ops and divide-by-zero: results and flags are registered at edge N. pronto=1 for the cycle after edge N. ocupado stays 0.
- mult/div: at edge N, operands load, ocupado goes to 1, and the counter goes to 0.
- mult/div iterations run on edges N+1 … N+LARGURA.
- At edge N+LARGURA: results and flags are written, pronto=1 for one cycle, ocupado goes to 0, state returns to OCIOSO.
- Back-to-back: inicio may be asserted in the cycle pronto=1 and is accepted at that edge.
- pronto is never high for two consecutive cycles unless two single-cycle ops are started back-to-back.
- Reset mid-operation, including the pronto cycle:
  - Aborts immediately at the next edge.
  - All outputs take their reset values.
  - No pronto is produced for the aborted op.
  - reset has priority over inicio.
- The counter is $clog2(LARGURA+1) bits wide and never wraps.

## Test plan
- Reset: assert reset 2 cycles → all outputs at reset values, zero=1. Then add 0x7FFF+0x0001 → saida_ula=0x8000, overflow=1, zero=0, pronto one cycle after start edge.
- mult: 0x1234 × 0x0100 → ocupado high 16 cycles, pronto at edge N+16, saida_hi=0x0012, saida_ula=0x3400, overflow=1. Then 0xFFFF × 0xFFFF → hi 0xFFFE, lo 0x0001.
- div: 100 ÷ 7 → saida_ula=0x000E, saida_hi=0x0002, pronto at N+16. Then 0x1234 ÷ 0 → pronto at N, saida_ula=0xFFFF, saida_hi=0x1234, div_zero=1.
- slt signed vs unsigned: A=0xFFFF, B=0x0001 → op 100 gives 0x0000, zero=1; op 111 gives 0xFFFF, zero=0.
- Busy protection: start mult 3×5, pulse inicio with op=010 and new operands at cycle N+5 → ignored; result hi 0, lo 0x000F at N+16. A second start in the pronto cycle is accepted.
- Reset mid-div at cycle N+8 → outputs at reset values, ocupado=0, no pronto. A following and of 0xF0F0 & 0x0FF0 gives 0x00F0.
